slice_serial_adder: RTL



---
 rtl/slice_serial_adder_if.sv | 26 ++
 rtl/slice_serial_adder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/slice_serial_adder_if.sv
// Start/done handshake and result bus between the ALU operand registers and
// the slice-serial adder.
interface slice_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, overflow, zero
    );
endinterface

// File: rtl/slice_serial_adder.sv
// Multi-cycle add/subtract: one 4-bit carry-lookahead slice per clock, with the
// slice carry-out registered as the next slice's carry-in.
module ssa_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c2,
    output logic       c3
);
    logic [3:0] p, g;
    logic       c0, c1;

    assign p  = a ^ b;
    assign g  = a & b;
    assign c0 = g[0] | (p[0] & cin);
    assign c1 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c2 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c3 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s  = p ^ {c2, c1, c0, cin};
endmodule

module slice_serial_adder #(
    parameter int WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    slice_serial_adder_if.slave bus
);
    localparam int SLICES = WIDTH / 4;
    localparam int CW     = $clog2(SLICES);
    localparam int LW     = CW + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_r, b_r, sum_r, sum_nxt;
    logic             cout_r, ovf_r, zero_r;
    logic [LW-1:0]    lo;
    logic             last;
    logic [3:0]       s_slice;
    logic             c2, c3;

    assign lo   = {cnt, 2'b00};
    assign last = (cnt == CW'(SLICES - 1));

    ssa_cla4 u_slice (
        .a   (a_r[lo +: 4]),
        .b   (b_r[lo +: 4]),
        .cin (carry),
        .s   (s_slice),
        .c2  (c2),
        .c3  (c3)
    );

    // Merged result including the slice being computed, so zero covers the final slice.
    always_comb begin
        sum_nxt          = sum_r;
        sum_nxt[lo +: 4] = s_slice;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    // Subtract as A + ~B + 1: invert B here, carry-in supplies the +1.
                    a_r    <= bus.a;
                    b_r    <= bus.b ^ {WIDTH{bus.sub}};
                    carry  <= bus.sub;
                    cnt    <= '0;
                    sum_r  <= '0;
                    cout_r <= 1'b0;
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end
                RUN: begin
                    sum_r <= sum_nxt;
                    carry <= c3;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout_r <= c3;
                        ovf_r  <= c3 ^ c2;
                        zero_r <= (sum_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;
    assign bus.zero     = zero_r;
endmodule
